// File: rtl/wb_port_arbiter_pkg.sv
// Shared writeback types: unit index, instruction id and the registered
// writeback packet handed to the register-file / commit stage.
package wb_port_arbiter_pkg;

  localparam int MAX_WB_UNITS          = 8;
  localparam int MAX_POSSIBLE_REG_BITS = 32;
  localparam int LOG2_MAX_IDS          = 3;

  typedef logic [$clog2(MAX_WB_UNITS)-1:0] wb_unit_idx_t;
  typedef logic [LOG2_MAX_IDS-1:0]         id_t;

  typedef struct packed {
    id_t                              id;
    logic                             valid;
    logic [MAX_POSSIBLE_REG_BITS-1:0] data;
  } wb_packet_t;

  // Index of the lowest set bit (0 when the vector is empty).
  function automatic wb_unit_idx_t lowest_set(input logic [MAX_WB_UNITS-1:0] v);
    wb_unit_idx_t idx;
    idx = '0;
    for (int i = MAX_WB_UNITS - 1; i >= 0; i--) begin
      if (v[i]) idx = wb_unit_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_picker.sv
// Round-robin priority picker: scans the request vector starting just after
// ptr (with wrap) and returns the first requester as one-hot and as an index.
module rr_priority_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;

  assign dbl = {req, req};

  // Rotate so bit 0 is the unit after ptr, then priority-encode the lowest bit.
  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    rot   = '0;
    idx   = '0;
    any   = 1'b0;
    grant = '0;
    for (int k = 0; k < N; k++) begin
      rot[k] = dbl[int'(ptr) + 1 + k];
    end
    for (int k = 0; k < N; k++) begin
      if (!any && rot[k]) begin
        any = 1'b1;
        idx = IW'((int'(ptr) + 1 + k) % N);
      end
    end
    if (any) grant = N'(1) << idx;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: grants one done unit per accepted cycle using
// round-robin order, with a lowest-index override for units that have waited
// MAX_WAIT cycles, and registers the winner into a writeback packet.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int MAX_WAIT  = 15,
  parameter int DATA_W    = MAX_POSSIBLE_REG_BITS
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                wb_stall,
  input  logic [NUM_UNITS-1:0]                unit_done,
  input  id_t  [NUM_UNITS-1:0]                unit_id,
  input  logic [NUM_UNITS-1:0][DATA_W-1:0]    unit_data,
  output logic [NUM_UNITS-1:0]                unit_ack,
  output wb_packet_t                          wb_out,
  output logic [$clog2(NUM_UNITS)-1:0]        wb_unit,
  output logic                                starve_event
);

  localparam int IW = $clog2(NUM_UNITS);

  logic [7:0]           wait_cnt [NUM_UNITS];
  logic [NUM_UNITS-1:0] starved;
  logic [NUM_UNITS-1:0] rr_grant;
  logic [NUM_UNITS-1:0] grant;
  logic [IW-1:0]        rr_ptr;
  logic [IW-1:0]        rr_idx;
  logic [IW-1:0]        grant_idx;
  logic                 rr_any;
  logic                 grant_any;
  logic                 force_grant;
  logic                 accept;

  // No grants while in reset or while writeback is suppressed.
  assign accept = rst_n & ~wb_stall;

  rr_priority_picker #(.N(NUM_UNITS)) picker (
    .req   (unit_done),
    .ptr   (rr_ptr),
    .grant (rr_grant),
    .idx   (rr_idx),
    .any   (rr_any)
  );

  // Units that are done and have waited long enough to override round robin.
  always_comb begin
    for (int i = 0; i < NUM_UNITS; i++) begin
      starved[i] = unit_done[i] && (wait_cnt[i] >= 8'(MAX_WAIT));
    end
  end

  // Grant selection: starved lowest index first, else the round-robin pick.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_any   = 1'b0;
    force_grant = 1'b0;
    if (accept) begin
      if (|starved) begin
        force_grant = 1'b1;
        grant_any   = 1'b1;
        grant_idx   = IW'(lowest_set(MAX_WB_UNITS'(starved)));
        grant       = NUM_UNITS'(1) << grant_idx;
      end else if (rr_any) begin
        grant_any = 1'b1;
        grant_idx = rr_idx;
        grant     = rr_grant;
      end
    end
  end

  assign unit_ack = grant;

  // Per-unit wait counters keep counting through stalls and saturate.
  // NOTE: the counters are control state, so every entry is reset explicitly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_UNITS; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        if (!unit_done[i] || grant[i]) wait_cnt[i] <= '0;
        else if (wait_cnt[i] < 8'(MAX_WAIT)) wait_cnt[i] <= wait_cnt[i] + 8'd1;
      end
    end
  end

  // Output packet, winner index and round-robin pointer; all frozen on stall.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_out       <= '0;
      wb_unit      <= '0;
      starve_event <= 1'b0;
      rr_ptr       <= IW'(NUM_UNITS - 1);
    end else if (accept) begin
      wb_out.valid <= grant_any;
      starve_event <= force_grant;
      if (grant_any) begin
        wb_out.id   <= unit_id[grant_idx];
        wb_out.data <= MAX_POSSIBLE_REG_BITS'(unit_data[grant_idx]);
        wb_unit     <= grant_idx;
        rr_ptr      <= grant_idx;
      end
    end else begin
      starve_event <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus randomized traffic,
// all checked against a cycle-level behavioural model of the arbitration rules.
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int MW = 3;
  localparam int DW = MAX_POSSIBLE_REG_BITS;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 wb_stall = 1'b0;
  logic [N-1:0]         unit_done = '0;
  id_t  [N-1:0]         unit_id = '0;
  logic [N-1:0][DW-1:0] unit_data = '0;
  logic [N-1:0]         unit_ack;
  wb_packet_t           wb_out;
  logic [1:0]           wb_unit;
  logic                 starve_event;

  int total = 0;
  int bad   = 0;

  // Behavioural model state.
  int         m_wait [N];
  int         m_last;
  wb_packet_t e_pkt;
  int         e_unit;
  bit         e_starve;
  int         last_g;

  wb_port_arbiter #(.NUM_UNITS(N), .MAX_WAIT(MW), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb_stall     (wb_stall),
    .unit_done    (unit_done),
    .unit_id      (unit_id),
    .unit_data    (unit_data),
    .unit_ack     (unit_ack),
    .wb_out       (wb_out),
    .wb_unit      (wb_unit),
    .starve_event (starve_event)
  );

  always #5 clk = ~clk;

  // Which unit should win this cycle (-1 if none) and whether it is forced.
  function automatic void mdl_pick(output int g, output bit f);
    g = -1;
    f = 1'b0;
    if (wb_stall || !rst_n) return;
    for (int i = 0; i < N; i++)
      if (g < 0 && unit_done[i] && m_wait[i] >= MW) begin g = i; f = 1'b1; end
    for (int k = 1; k <= N; k++)
      if (g < 0 && unit_done[(m_last + k) % N]) g = (m_last + k) % N;
  endfunction

  function automatic logic [N-1:0] mdl_ack();
    int g; bit f;
    mdl_pick(g, f);
    return (g < 0) ? '0 : (N'(1) << g);
  endfunction

  task automatic mdl_reset();
    foreach (m_wait[i]) m_wait[i] = 0;
    m_last   = N - 1;
    e_pkt    = '0;
    e_unit   = 0;
    e_starve = 1'b0;
    last_g   = -1;
  endtask

  // Advance one clock and move the model forward by the same edge.
  task automatic tick();
    int g; bit f;
    mdl_pick(g, f);
    last_g = g;
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (!unit_done[i] || g == i) m_wait[i] = 0;
      else if (m_wait[i] < MW) m_wait[i]++;
    end
    if (!wb_stall) begin
      e_pkt.valid = (g >= 0);
      e_starve    = f;
      if (g >= 0) begin
        e_pkt.id   = unit_id[g];
        e_pkt.data = unit_data[g];
        e_unit     = g;
        m_last     = g;
      end
    end else begin
      e_starve = 1'b0;
    end
    #1;
  endtask

  task automatic new_result(input int i);
    unit_id[i]   = id_t'($urandom);
    unit_data[i] = $urandom;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    unit_done = '1;
    mdl_reset();
    #2;
    total++;
    if ({wb_out, wb_unit, starve_event, unit_ack} !== '0) begin
      bad++;
      $display("FAIL reset_state: got pkt=%h unit=%0d starve=%b ack=%b want all zero",
               wb_out, wb_unit, starve_event, unit_ack);
    end
    @(negedge clk);
    unit_done = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    int seq [5] = '{0, 1, 2, 3, 0};
    @(negedge clk);
    for (int i = 0; i < N; i++) new_result(i);
    unit_done = '1;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++;
      if (unit_ack !== (N'(1) << seq[k])) begin
        bad++;
        $display("FAIL rr_ack[%0d]: got %b want unit %0d", k, unit_ack, seq[k]);
      end
      tick();
      total++;
      if (wb_out.valid !== 1'b1 || wb_unit !== 2'(seq[k]) || wb_out !== e_pkt) begin
        bad++;
        $display("FAIL rr_out[%0d]: got pkt=%h unit=%0d want pkt=%h unit=%0d",
                 k, wb_out, wb_unit, e_pkt, seq[k]);
      end
      @(negedge clk);
      new_result(seq[k]);
    end
    unit_done = '0;
    tick();
  endtask

  task automatic test_single();
    @(negedge clk);
    unit_done    = 4'b0100;
    unit_id[2]   = id_t'(5);
    unit_data[2] = 32'hDEADBEEF;
    #1;
    total++;
    if (unit_ack !== 4'b0100) begin
      bad++;
      $display("FAIL single_ack: got %b want 0100", unit_ack);
    end
    tick();
    total++;
    if (wb_out !== {id_t'(5), 1'b1, 32'hDEADBEEF} || wb_unit !== 2'd2) begin
      bad++;
      $display("FAIL single_out: got pkt=%h unit=%0d want id=5 valid=1 data=deadbeef unit=2",
               wb_out, wb_unit);
    end
    @(negedge clk);
    unit_done = '0;
    #1;
    tick();
    total++;
    if (wb_out.valid !== 1'b0 || unit_ack !== '0) begin
      bad++;
      $display("FAIL single_idle: got valid=%b ack=%b want 0/0", wb_out.valid, unit_ack);
    end
  endtask

  task automatic test_stall();
    wb_packet_t snap;
    snap = e_pkt;
    @(negedge clk);
    unit_done = 4'b0010;
    new_result(1);
    wb_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (unit_ack !== '0) begin
        bad++;
        $display("FAIL stall_ack[%0d]: got %b want 0000", k, unit_ack);
      end
      tick();
      total++;
      if (wb_out !== snap) begin
        bad++;
        $display("FAIL stall_hold[%0d]: got %h want %h", k, wb_out, snap);
      end
      @(negedge clk);
    end
    wb_stall = 1'b0;
    #1;
    total++;
    if (unit_ack !== 4'b0010) begin
      bad++;
      $display("FAIL stall_release_ack: got %b want 0010", unit_ack);
    end
    tick();
    total++;
    if (wb_out !== e_pkt || wb_unit !== 2'd1 || starve_event !== e_starve) begin
      bad++;
      $display("FAIL stall_release_out: got pkt=%h unit=%0d starve=%b want pkt=%h unit=1 starve=%b",
               wb_out, wb_unit, starve_event, e_pkt, e_starve);
    end
    @(negedge clk);
    unit_done = '0;
    tick();
  endtask

  task automatic test_starve();
    @(negedge clk);
    wb_stall  = 1'b1;
    unit_done = 4'b1000;
    new_result(3);
    tick();
    @(negedge clk);
    tick();
    @(negedge clk);
    unit_done = 4'b1101;
    new_result(0);
    new_result(2);
    tick();
    @(negedge clk);
    wb_stall = 1'b0;
    #1;
    total++;
    if (unit_ack !== 4'b1000 || unit_ack !== mdl_ack()) begin
      bad++;
      $display("FAIL starve_ack: got %b want 1000", unit_ack);
    end
    tick();
    total++;
    if (starve_event !== 1'b1 || wb_unit !== 2'd3 || wb_out !== e_pkt) begin
      bad++;
      $display("FAIL starve_out: got starve=%b unit=%0d pkt=%h want starve=1 unit=3 pkt=%h",
               starve_event, wb_unit, wb_out, e_pkt);
    end
    @(negedge clk);
    unit_done[3] = 1'b0;
    #1;
    total++;
    if (unit_ack !== mdl_ack()) begin
      bad++;
      $display("FAIL starve_after_ack: got %b want %b", unit_ack, mdl_ack());
    end
    tick();
    total++;
    if (starve_event !== 1'b0 || wb_out !== e_pkt) begin
      bad++;
      $display("FAIL starve_after_out: got starve=%b pkt=%h want starve=0 pkt=%h",
               starve_event, wb_out, e_pkt);
    end
    @(negedge clk);
    unit_done = '0;
    tick();
  endtask

  task automatic test_idle();
    int resume;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      unit_done = '0;
      #1;
      tick();
      total++;
      if (unit_ack !== '0 || wb_out.valid !== 1'b0) begin
        bad++;
        $display("FAIL idle[%0d]: got ack=%b valid=%b want 0000/0", k, unit_ack, wb_out.valid);
      end
    end
    resume = (m_last + 1) % N;
    @(negedge clk);
    for (int i = 0; i < N; i++) new_result(i);
    unit_done = '1;
    #1;
    total++;
    if (unit_ack !== (N'(1) << resume)) begin
      bad++;
      $display("FAIL idle_resume: got %b want unit %0d", unit_ack, resume);
    end
    tick();
    @(negedge clk);
    new_result(last_g);
  endtask

  task automatic test_reset_mid();
    tick();
    #1;
    total++;
    if (wb_out.valid !== 1'b1) begin
      bad++;
      $display("FAIL midrst_pre: got valid=%b want 1", wb_out.valid);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    mdl_reset();
    #1;
    total++;
    if (wb_out.valid !== 1'b0 || unit_ack !== '0 || starve_event !== 1'b0) begin
      bad++;
      $display("FAIL midrst_async: got valid=%b ack=%b starve=%b want 0",
               wb_out.valid, unit_ack, starve_event);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) new_result(i);
    #1;
    total++;
    if (unit_ack !== 4'b0001) begin
      bad++;
      $display("FAIL midrst_first: got %b want 0001", unit_ack);
    end
    tick();
    total++;
    if (wb_unit !== 2'd0 || wb_out !== e_pkt) begin
      bad++;
      $display("FAIL midrst_out: got unit=%0d pkt=%h want unit=0 pkt=%h", wb_unit, wb_out, e_pkt);
    end
    @(negedge clk);
    unit_done = '0;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (last_g == i) begin
          unit_done[i] = 1'($urandom_range(0, 1));
          new_result(i);
        end else if (!unit_done[i] && $urandom_range(0, 2) == 0) begin
          unit_done[i] = 1'b1;
          new_result(i);
        end
      end
      wb_stall = ($urandom_range(0, 4) == 0);
      #1;
      total++;
      if (unit_ack !== mdl_ack() || !$onehot0(unit_ack)) begin
        bad++;
        $display("FAIL rand_ack[%0d]: got %b want %b", c, unit_ack, mdl_ack());
      end
      tick();
      total++;
      if ({wb_out, wb_unit, starve_event} !== {e_pkt, 2'(e_unit), e_starve}) begin
        bad++;
        $display("FAIL rand_out[%0d]: got pkt=%h unit=%0d starve=%b want pkt=%h unit=%0d starve=%b",
                 c, wb_out, wb_unit, starve_event, e_pkt, e_unit, e_starve);
      end
    end
    @(negedge clk);
    wb_stall  = 1'b0;
    unit_done = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_stall();
    test_starve();
    test_idle();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
